phi2_clock_gen: RTL and testbench

Programmable PHI2 generator for the 65C816 interface, running entirely in the single system clock domain. It divides `i_Clk` by a runtime-loadable ratio with a programmable high-phase length and produces a registered `o_Phi2` for external pins. It also produces one-clock rise/fall enable strobes for internal logic, which must never use `o_Phi2` as a clock. Ratio changes apply glitch-free at period boundaries, and the block supports run/stop and optional wait-state stretching of the high phase.

---
 rtl/phi_clk_pkg.sv | 13 +
 rtl/phi2_clock_gen.sv | 142 ++++++++++++++
 tb/tb_phi2_clock_gen.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/phi_clk_pkg.sv
// Shared types and constants for the PHI2 clock generator.
package phi_clk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOW     = 2'd1,
    HIGH    = 2'd2,
    STRETCH = 2'd3
  } phi_state_t;

  localparam int PHI_MIN_DIV = 2;

endpackage

// File: rtl/phi2_clock_gen.sv
// Programmable PHI2 generator: divides i_Clk by a loadable ratio, emits rise/fall enables.
// Optional wait-state stretching of the high phase is enabled with `define PHI2_STRETCH_EN.
module phi2_clock_gen
  import phi_clk_pkg::*;
#(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned DEF_DIV  = 4,
  parameter int unsigned DEF_HIGH = 2
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Run,
  input  logic             i_Load,
  input  logic [CNT_W-1:0] i_Div,
  input  logic [CNT_W-1:0] i_High,
  input  logic             i_Stretch,
  output logic             o_Phi2,
  output logic             o_Rise_En,
  output logic             o_Fall_En,
  output logic             o_Load_Ack,
  output logic             o_Load_Err,
  output logic             o_Running,
  output phi_state_t       o_State
);

  localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(PHI_MIN_DIV);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(DEF_HIGH);

  phi_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] act_div, act_high, pend_div, pend_high;
  logic             pend_valid;
  logic [CNT_W-1:0] low_len;
  logic             load_ok, apply, boundary, rise_d, fall_d, stretch_req;

`ifdef PHI2_STRETCH_EN
  assign stretch_req = i_Stretch;
`else
  logic unused_stretch;
  assign unused_stretch = i_Stretch;
  assign stretch_req    = 1'b0;
`endif

  // i_Load is a one-cycle strobe with no back-pressure: a valid request is
  // always accepted into the pending slot (latest wins) and acknowledged by
  // o_Load_Ack when it becomes active; an invalid one gets o_Load_Err.
  assign load_ok = (i_Div >= MIN_DIV) && (i_High != '0) && (i_High <= (i_Div - ONE));
  assign low_len = act_div - act_high;
  assign o_State = state;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    apply    = 1'b0;
    boundary = 1'b0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    case (state)
      IDLE: begin
        if (i_Run) begin
          state_d = LOW;
          cnt_d   = '0;
          apply   = 1'b1;
        end
      end
      LOW: begin
        cnt_d = cnt + ONE;
        if (cnt == (low_len - ONE)) begin
          state_d = HIGH;
          rise_d  = 1'b1;
        end
      end
      HIGH: begin
        if (cnt == (act_div - ONE)) begin
          if (stretch_req) state_d = STRETCH;
          else             boundary = 1'b1;
        end else begin
          cnt_d = cnt + ONE;
        end
      end
      STRETCH: begin
        // Counter stays frozen at the last high count until the request drops.
        if (!stretch_req) boundary = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (boundary) begin
      cnt_d  = '0;
      fall_d = 1'b1;
      if (i_Run) begin
        state_d = LOW;
        apply   = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      o_Phi2     <= 1'b0;
      o_Rise_En  <= 1'b0;
      o_Fall_En  <= 1'b0;
      o_Load_Ack <= 1'b0;
      o_Load_Err <= 1'b0;
      o_Running  <= 1'b0;
      act_div    <= DIV_RST;
      act_high   <= HIGH_RST;
      pend_div   <= DIV_RST;
      pend_high  <= HIGH_RST;
      pend_valid <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      o_Phi2     <= (state_d == HIGH) || (state_d == STRETCH);
      o_Rise_En  <= rise_d;
      o_Fall_En  <= fall_d;
      o_Load_Ack <= apply && pend_valid;
      o_Load_Err <= i_Load && !load_ok;
      o_Running  <= (state_d != IDLE);

      if (apply && pend_valid) begin
        act_div  <= pend_div;
        act_high <= pend_high;
      end
      // A load on the applying edge refills the slot after the old value moved.
      if (i_Load && load_ok) begin
        pend_div   <= i_Div;
        pend_high  <= i_High;
        pend_valid <= 1'b1;
      end else if (apply) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_phi2_clock_gen.sv
// Self-checking bench for phi2_clock_gen: directed cycles feed an expected-output queue.
module tb_phi2_clock_gen;
  import phi_clk_pkg::*;

  localparam logic [5:0] V_I   = 6'b000000;
  localparam logic [5:0] V_L   = 6'b000001;
  localparam logic [5:0] V_LF  = 6'b001001;
  localparam logic [5:0] V_LFA = 6'b001101;
  localparam logic [5:0] V_LA  = 6'b000101;
  localparam logic [5:0] V_HR  = 6'b110001;
  localparam logic [5:0] V_H   = 6'b100001;
  localparam logic [5:0] V_IF  = 6'b001000;
  localparam logic [5:0] V_ERR = 6'b000010;

  logic       i_Clk;
  logic       i_Rst_n;
  logic       i_Run;
  logic       i_Load;
  logic [3:0] i_Div;
  logic [3:0] i_High;
  logic       i_Stretch;
  logic       o_Phi2, o_Rise_En, o_Fall_En, o_Load_Ack, o_Load_Err, o_Running;
  phi_state_t o_State;

  logic [5:0] exp_q[$];
  string      name_q[$];
  int         errors = 0;
  int         checks = 0;

  phi2_clock_gen #(.CNT_W(4), .DEF_DIV(4), .DEF_HIGH(2)) dut (
    .i_Clk      (i_Clk),
    .i_Rst_n    (i_Rst_n),
    .i_Run      (i_Run),
    .i_Load     (i_Load),
    .i_Div      (i_Div),
    .i_High     (i_High),
    .i_Stretch  (i_Stretch),
    .o_Phi2     (o_Phi2),
    .o_Rise_En  (o_Rise_En),
    .o_Fall_En  (o_Fall_En),
    .o_Load_Ack (o_Load_Ack),
    .o_Load_Err (o_Load_Err),
    .o_Running  (o_Running),
    .o_State    (o_State)
  );

  // Clock and reset
  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: one expected output vector per clock edge while entries are queued
  logic [5:0] mon_act, mon_exp;
  string      mon_name;
  always @(posedge i_Clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = {o_Phi2, o_Rise_En, o_Fall_En, o_Load_Ack, o_Load_Err, o_Running};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s: phi2/rise/fall/ack/err/run got %b expected %b", mon_name, mon_act, mon_exp);
      end
    end
  end

  // Driver tasks
  task automatic cyc(input logic run, input logic load, input logic [3:0] div,
                     input logic [3:0] high, input logic str,
                     input logic [5:0] exp, input string nm);
    i_Run     = run;
    i_Load    = load;
    i_Div     = div;
    i_High    = high;
    i_Stretch = str;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge i_Clk);
    #2;
  endtask

  task automatic step(input logic [5:0] exp, input string nm);
    cyc(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, exp, nm);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_outs"}, {2'b00, o_Phi2, o_Rise_En, o_Fall_En, o_Load_Ack, o_Load_Err, o_Running}, 8'h00);
    chk({nm, "_state"}, {6'b0, o_State}, {6'b0, IDLE});
  endtask

  initial begin
    i_Rst_n = 1'b1; i_Run = 1'b0; i_Load = 1'b0;
    i_Div = '0; i_High = '0; i_Stretch = 1'b0;
    #3 i_Rst_n = 1'b0;
    repeat (2) @(posedge i_Clk);
    #2;
    chk_idle_outputs("reset");
    i_Rst_n = 1'b1;

    // Default 4/2 ratio: 0,0,1,1
    step(V_L,  "start_low0");
    step(V_L,  "start_low1");
    step(V_HR, "def_rise");
    step(V_H,  "def_high");
    step(V_LF, "def_fall");
    step(V_L,  "def_low");
    step(V_HR, "def_rise2");
    step(V_H,  "def_high2");

    // Mid-period load of 6/1 waits for the boundary
    step(V_LF, "pre_load_fall");
    cyc(1'b1, 1'b1, 4'd6, 4'd1, 1'b0, V_L, "load61_mid");
    step(V_HR, "old_rise");
    step(V_H,  "old_high");
    step(V_LFA, "ack61");
    for (int i = 0; i < 4; i++) step(V_L, "low61");
    step(V_HR, "rise61");
    step(V_LF, "fall61");

    // Rejected loads, then a load landing on the boundary clock
    cyc(1'b1, 1'b1, 4'd1, 4'd0, 1'b0, V_L | V_ERR, "err_div1");
    cyc(1'b1, 1'b1, 4'd5, 4'd5, 1'b0, V_L | V_ERR, "err_high_eq_div");
    cyc(1'b1, 1'b1, 4'd4, 4'd3, 1'b0, V_L, "load43");
    step(V_L,  "low61_last");
    step(V_HR, "rise61b");
    cyc(1'b1, 1'b1, 4'd4, 4'd2, 1'b0, V_LFA, "ack43_boundary_load");
    step(V_HR, "rise43");
    step(V_H,  "high43a");
    step(V_H,  "high43b");
    step(V_LFA, "ack42");
    step(V_L,  "low42");
    step(V_HR, "rise42");
    step(V_H,  "high42");
    step(V_LF, "fall42_noack");

    // Stretch held for 3 clocks starting at the last high clock
    step(V_L,  "pre_stretch_low");
    step(V_HR, "pre_stretch_rise");
    step(V_H,  "pre_stretch_high");
`ifdef PHI2_STRETCH_EN
    cyc(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, V_H,  "stretch1");
    cyc(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, V_H,  "stretch2");
    cyc(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, V_H,  "stretch3");
    cyc(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, V_LF, "stretch_fall");
`else
    cyc(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, V_LF, "nostretch_fall");
    cyc(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, V_L,  "nostretch_low");
    cyc(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, V_HR, "nostretch_rise");
    cyc(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, V_H,  "nostretch_high");
    step(V_LF, "nostretch_fall2");
`endif

    // Run dropped in LOW: period completes, pending 6/3 held across IDLE
    cyc(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, V_L,  "stop_low");
    cyc(1'b0, 1'b1, 4'd6, 4'd3, 1'b0, V_HR, "stop_rise_load63");
    cyc(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, V_H,  "stop_high");
    cyc(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, V_IF, "stop_fall_idle");
    cyc(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, V_I,  "idle0");
    cyc(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, V_I,  "idle1");
    step(V_LA, "restart_ack63");
    step(V_L,  "low63a");
    step(V_L,  "low63b");
    step(V_HR, "rise63");

    // Async reset while PHI2 is high
    i_Rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    @(posedge i_Clk);
    #2;
    chk_idle_outputs("reset_held");
    i_Rst_n = 1'b1;
    step(V_L,  "rst_low0");
    step(V_L,  "rst_low1");
    step(V_HR, "rst_rise_default");
    step(V_H,  "rst_high_default");
    step(V_LF, "rst_fall_default");

    i_Run = 1'b0;
    repeat (2) @(posedge i_Clk);
    #2;
    chk("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
